// File: rtl/cache_def_pkg.sv
// Shared geometry, bus/memory record types and the line word-merge helper
// for the direct-mapped cache controller.
package cache_def_pkg;

    localparam int TAGMSB      = 31;
    localparam int TAGLSB      = 14;
    localparam int CACHE_INDEX = 1024;

    typedef struct packed {
        logic                valid;
        logic                dirty;
        logic [TAGMSB:TAGLSB] tag;
    } cache_tag_type;

    typedef struct packed {
        logic [9:0] index;
        logic       we;
    } cache_req_type;

    typedef logic [127:0] cache_data_type;

    typedef struct packed {
        logic [31:0] addr;
        logic [31:0] data;
        logic        rw;
        logic        valid;
    } cpu_req_type;

    typedef struct packed {
        logic [31:0] data;
        logic        ready;
    } cpu_result_type;

    typedef struct packed {
        logic [31:0]  addr;
        logic [127:0] data;
        logic         rw;
        logic         valid;
    } mem_req_type;

    typedef struct packed {
        logic [127:0] data;
        logic         ready;
    } mem_data_type;

    // Replace one 32-bit word of a line; word 0 occupies bits [31:0].
    function automatic cache_data_type merge_word(input cache_data_type line,
                                                  input logic [1:0]     sel,
                                                  input logic [31:0]    word);
        cache_data_type r;
        r = line;
        r[{sel, 5'b0} +: 32] = word;
        return r;
    endfunction

endpackage

// File: rtl/dm_cache_ctrl.sv
// Direct-mapped, write-back, write-allocate cache controller. Handshakes:
// cpu_req is taken only in IDLE; mem_req is held stable until mem_res.ready.
module dm_cache_ctrl
    import cache_def_pkg::*;
(
    input  logic           clk,
    input  logic           rst,
    input  cpu_req_type    cpu_req,
    output cpu_result_type cpu_res,
    output mem_req_type    mem_req,
    input  mem_data_type   mem_res,
    output cache_req_type  tag_req,
    output cache_req_type  data_req,
    output cache_tag_type  tag_write,
    input  cache_tag_type  tag_read,
    output cache_data_type data_write,
    input  cache_data_type data_read
);

    typedef enum logic [1:0] {
        IDLE,
        COMPARE_TAG,
        ALLOCATE,
        WRITE_BACK
    } state_e;

    typedef struct packed {
        logic [31:0] addr;
        logic [31:0] data;
        logic        rw;
    } req_t;

    state_e         state_q, state_d;
    req_t           req_q, req_d;
    logic [31:0]    wb_addr_q, wb_addr_d;
    cache_data_type wb_data_q, wb_data_d;

    logic           hit;
    logic [1:0]     word_sel;
    logic [9:0]     req_index;

    assign req_index = req_q.addr[13:4];
    assign word_sel  = req_q.addr[3:2];
    assign hit       = tag_read.valid && (tag_read.tag == req_q.addr[TAGMSB:TAGLSB]);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            req_q     <= '0;
            wb_addr_q <= '0;
            wb_data_q <= '0;
        end else begin
            state_q   <= state_d;
            req_q     <= req_d;
            wb_addr_q <= wb_addr_d;
            wb_data_q <= wb_data_d;
        end
    end

    always_comb begin
        state_d        = state_q;
        req_d          = req_q;
        wb_addr_d      = wb_addr_q;
        wb_data_d      = wb_data_q;
        cpu_res        = '0;
        mem_req        = '0;
        tag_write      = '0;
        data_write     = '0;
        tag_req.index  = (state_q == IDLE) ? cpu_req.addr[13:4] : req_index;
        tag_req.we     = 1'b0;
        data_req.index = (state_q == IDLE) ? cpu_req.addr[13:4] : req_index;
        data_req.we    = 1'b0;

        case (state_q)
            IDLE: begin
                if (cpu_req.valid) begin
                    req_d.addr = cpu_req.addr;
                    req_d.data = cpu_req.data;
                    req_d.rw   = cpu_req.rw;
                    state_d    = COMPARE_TAG;
                end
            end

            COMPARE_TAG: begin
                if (hit) begin
                    cpu_res.ready = 1'b1;
                    cpu_res.data  = data_read[{word_sel, 5'b0} +: 32];
                    if (req_q.rw) begin
                        tag_req.we      = 1'b1;
                        data_req.we     = 1'b1;
                        tag_write.valid = 1'b1;
                        tag_write.dirty = 1'b1;
                        tag_write.tag   = req_q.addr[TAGMSB:TAGLSB];
                        data_write      = merge_word(data_read, word_sel, req_q.data);
                    end
                    state_d = IDLE;
                end else if (tag_read.valid && tag_read.dirty) begin
                    // Capture the victim now; the arrays are rewritten during ALLOCATE.
                    wb_addr_d = {tag_read.tag, req_index, 4'b0};
                    wb_data_d = data_read;
                    state_d   = WRITE_BACK;
                end else begin
                    state_d = ALLOCATE;
                end
            end

            WRITE_BACK: begin
                mem_req.addr  = wb_addr_q;
                mem_req.data  = wb_data_q;
                mem_req.rw    = 1'b1;
                mem_req.valid = 1'b1;
                if (mem_res.ready) begin
                    state_d = ALLOCATE;
                end
            end

            ALLOCATE: begin
                mem_req.addr  = {req_q.addr[31:4], 4'b0};
                mem_req.rw    = 1'b0;
                mem_req.valid = 1'b1;
                if (mem_res.ready) begin
                    tag_req.we      = 1'b1;
                    data_req.we     = 1'b1;
                    tag_write.valid = 1'b1;
                    tag_write.dirty = 1'b0;
                    tag_write.tag   = req_q.addr[TAGMSB:TAGLSB];
                    data_write      = mem_res.data;
                    state_d         = COMPARE_TAG;
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase

        // A reset edge abandons the transaction, so no array write may land with it.
        if (rst) begin
            tag_req.we    = 1'b0;
            data_req.we   = 1'b0;
            cpu_res.ready = 1'b0;
        end
    end

endmodule

// File: tb/tb_dm_cache_ctrl.sv
// Directed bench for dm_cache_ctrl: behavioural tag/data arrays, a memory
// responder inside the transaction task, and a table of hand-computed vectors.
module tb_dm_cache_ctrl;
    import cache_def_pkg::*;

    logic           clk;
    logic           rst;
    cpu_req_type    cpu_req;
    cpu_result_type cpu_res;
    mem_req_type    mem_req;
    mem_data_type   mem_res;
    cache_req_type  tag_req;
    cache_req_type  data_req;
    cache_tag_type  tag_write;
    cache_tag_type  tag_read;
    cache_data_type data_write;
    cache_data_type data_read;

    cache_tag_type  tag_mem  [CACHE_INDEX];
    cache_data_type data_mem [CACHE_INDEX];

    int n_cmp  = 0;
    int n_fail = 0;

    localparam logic [127:0] L1   = 128'h44444444_33333333_22222222_11111111;
    localparam logic [127:0] L1W  = 128'h44444444_DEADBEEF_22222222_11111111;
    localparam logic [127:0] L2   = 128'hA3A3A3A3_A2A2A2A2_A1A1A1A1_A0A0A0A0;
    localparam logic [127:0] L3   = 128'h33330003_33330002_33330001_33330000;
    localparam logic [127:0] L3W  = 128'h33330003_33330002_33330001_12345678;
    localparam logic [127:0] L4   = 128'hCAFEF00D_77777777_66666666_55555555;
    localparam logic [127:0] L5   = 128'h99990003_99990002_99990001_99990000;
    localparam logic [127:0] JUNK = 128'hBAD0BAD0_BAD0BAD0_BAD0BAD0_BAD0BAD0;
    localparam logic [127:0] Z    = 128'h0;

    typedef struct {
        logic [31:0]  addr;
        logic [31:0]  data;
        logic         rw;
        int           delay;
        logic [127:0] fill;
        int           exp_cyc;
        logic         chk_data;
        logic [31:0]  exp_data;
        logic         exp_wb;
        logic [31:0]  exp_wb_addr;
        logic [127:0] exp_wb_data;
        logic         exp_alloc;
        logic [31:0]  exp_alloc_addr;
        logic [19:0]  exp_tag;
        logic [127:0] exp_line;
    } vec_t;

    vec_t vecs [8];
    vec_t retry_vec;

    dm_cache_ctrl dut (
        .clk        (clk),
        .rst        (rst),
        .cpu_req    (cpu_req),
        .cpu_res    (cpu_res),
        .mem_req    (mem_req),
        .mem_res    (mem_res),
        .tag_req    (tag_req),
        .data_req   (data_req),
        .tag_write  (tag_write),
        .tag_read   (tag_read),
        .data_write (data_write),
        .data_read  (data_read)
    );

    // Clock and behavioural arrays
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        for (int i = 0; i < CACHE_INDEX; i++) begin
            tag_mem[i]  = '0;
            data_mem[i] = '0;
        end
    end

    always @(posedge clk) begin
        if (tag_req.we)  tag_mem[tag_req.index]   <= tag_write;
        if (data_req.we) data_mem[data_req.index] <= data_write;
    end

    assign tag_read  = tag_mem[tag_req.index];
    assign data_read = data_mem[data_req.index];

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, n_cmp=%0d", n_cmp);
        $fatal(1, "watchdog");
    end

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // Issue one request, answer memory requests after v.delay extra cycles,
    // then compare latency, data, memory traffic and the resulting array entry.
    task automatic apply_vec(input vec_t v, input string nm);
        int           cyc;
        int           mem_cnt;
        int           ready_cyc;
        int           unstable;
        logic [31:0]  rdata;
        logic         wb_seen;
        logic         alloc_seen;
        logic [31:0]  wb_addr;
        logic [127:0] wb_data;
        logic [31:0]  alloc_addr;
        mem_req_type  snap;

        mem_cnt = 0; ready_cyc = -1; unstable = 0; rdata = '0;
        wb_seen = 1'b0; alloc_seen = 1'b0; wb_addr = '0; wb_data = '0;
        alloc_addr = '0; snap = '0;

        @(posedge clk); #1;
        cpu_req = '{addr: v.addr, data: v.data, rw: v.rw, valid: 1'b1};
        mem_res = '0;
        cyc = 0;
        while (cyc < 100) begin
            @(posedge clk); #1;
            cpu_req.valid = 1'b0;
            mem_res.ready = 1'b0;
            cyc++;
            #1;
            if (cpu_res.ready) begin
                ready_cyc = cyc;
                rdata     = cpu_res.data;
                break;
            end
            if (mem_req.valid) begin
                if (mem_cnt == 0) begin
                    snap = mem_req;
                    if (mem_req.rw) begin
                        wb_seen = 1'b1; wb_addr = mem_req.addr; wb_data = mem_req.data;
                    end else begin
                        alloc_seen = 1'b1; alloc_addr = mem_req.addr;
                    end
                end else if (mem_req !== snap) begin
                    unstable++;
                end
                if (mem_cnt == v.delay) begin
                    mem_res.ready = 1'b1;
                    mem_res.data  = snap.rw ? JUNK : v.fill;
                    mem_cnt = 0;
                end else begin
                    mem_cnt++;
                end
            end
        end

        chk({nm, ".ready_cycle"}, 128'(ready_cyc), 128'(v.exp_cyc));
        if (v.chk_data) chk({nm, ".rdata"}, 128'(rdata), 128'(v.exp_data));
        chk({nm, ".wb_seen"}, 128'(wb_seen), 128'(v.exp_wb));
        if (v.exp_wb) begin
            chk({nm, ".wb_addr"}, 128'(wb_addr), 128'(v.exp_wb_addr));
            chk({nm, ".wb_data"}, wb_data, v.exp_wb_data);
        end
        chk({nm, ".alloc_seen"}, 128'(alloc_seen), 128'(v.exp_alloc));
        if (v.exp_alloc) chk({nm, ".alloc_addr"}, 128'(alloc_addr), 128'(v.exp_alloc_addr));
        chk({nm, ".mem_req_stable"}, 128'(unstable), 128'(0));

        // Let any write-hit update land before inspecting the arrays.
        @(posedge clk); #1;
        chk({nm, ".tag_entry"}, 128'(tag_mem[v.addr[13:4]]), 128'(v.exp_tag));
        chk({nm, ".data_line"}, data_mem[v.addr[13:4]], v.exp_line);
    endtask

    initial begin
        //        addr          data          rw    dly fill cyc chk  exp_data      wb    wb_addr       wb_data al    al_addr       tag        line
        vecs[0] = '{32'h0000_1004, 32'h0,        1'b0, 3,  L1,  6,  1'b1, 32'h22222222, 1'b0, 32'h0,        Z,   1'b1, 32'h0000_1000, 20'h80000, L1};
        vecs[1] = '{32'h0000_1008, 32'hDEADBEEF, 1'b1, 0,  Z,   1,  1'b0, 32'h0,        1'b0, 32'h0,        Z,   1'b0, 32'h0,         20'hC0000, L1W};
        vecs[2] = '{32'h0000_1008, 32'h0,        1'b0, 0,  Z,   1,  1'b1, 32'hDEADBEEF, 1'b0, 32'h0,        Z,   1'b0, 32'h0,         20'hC0000, L1W};
        vecs[3] = '{32'h0004_1000, 32'h0,        1'b0, 0,  L2,  4,  1'b1, 32'hA0A0A0A0, 1'b1, 32'h0000_1000, L1W, 1'b1, 32'h0004_1000, 20'h80010, L2};
        vecs[4] = '{32'h0000_100C, 32'h0,        1'b0, 20, L1W, 23, 1'b1, 32'h44444444, 1'b0, 32'h0,        Z,   1'b1, 32'h0000_1000, 20'h80000, L1W};
        vecs[5] = '{32'h0000_2000, 32'h12345678, 1'b1, 1,  L3,  4,  1'b0, 32'h0,        1'b0, 32'h0,        Z,   1'b1, 32'h0000_2000, 20'hC0000, L3W};
        vecs[6] = '{32'h0000_2000, 32'h0,        1'b0, 0,  Z,   1,  1'b1, 32'h12345678, 1'b0, 32'h0,        Z,   1'b0, 32'h0,         20'hC0000, L3W};
        vecs[7] = '{32'hFFFF_FFFC, 32'h0,        1'b0, 2,  L4,  5,  1'b1, 32'hCAFEF00D, 1'b0, 32'h0,        Z,   1'b1, 32'hFFFF_FFF0, 20'hBFFFF, L4};
        retry_vec = '{32'h0000_3FF0, 32'h0,      1'b0, 0,  L5,  3,  1'b1, 32'h99990000, 1'b0, 32'h0,        Z,   1'b1, 32'h0000_3FF0, 20'h80000, L5};

        // Reset: outputs idle, index follows cpu_req, stray mem_res.ready ignored
        rst = 1'b1;
        cpu_req = '0;
        mem_res = '0;
        repeat (3) @(posedge clk);
        #1;
        cpu_req.addr  = 32'h0000_3FF0;
        mem_res       = '{data: JUNK, ready: 1'b1};
        #1;
        chk("reset.cpu_ready", 128'(cpu_res.ready), 128'(0));
        chk("reset.mem_valid", 128'(mem_req.valid), 128'(0));
        chk("reset.tag_we",    128'(tag_req.we),    128'(0));
        chk("reset.data_we",   128'(data_req.we),   128'(0));
        chk("idle.index",      128'(tag_req.index), 128'(10'h3FF));
        @(posedge clk); #1;
        rst = 1'b0;
        #1;
        chk("idle.stray_ready_tag_we",  128'(tag_req.we),    128'(0));
        chk("idle.stray_ready_data_we", 128'(data_req.we),   128'(0));
        chk("idle.mem_valid",           128'(mem_req.valid), 128'(0));
        @(posedge clk); #1;
        mem_res = '0;

        for (int i = 0; i < 8; i++) begin
            apply_vec(vecs[i], $sformatf("vec%0d", i));
        end

        // Back-to-back read hits with valid held: ready on every other cycle
        @(posedge clk); #1;
        cpu_req = '{addr: 32'h0000_1004, data: 32'h0, rw: 1'b0, valid: 1'b1};
        for (int c = 1; c <= 8; c++) begin
            @(posedge clk); #2;
            chk($sformatf("b2b.ready_c%0d", c), 128'(cpu_res.ready), 128'(c % 2));
            if (cpu_res.ready) chk($sformatf("b2b.data_c%0d", c), 128'(cpu_res.data), 128'(32'h22222222));
        end
        #1;
        cpu_req.valid = 1'b0;
        @(posedge clk); #1;

        // Reset in the third ALLOCATE cycle, with a coincident mem_res.ready
        @(posedge clk); #1;
        cpu_req = '{addr: 32'h0000_3FF0, data: 32'h0, rw: 1'b0, valid: 1'b1};
        for (int c = 1; c <= 4; c++) begin
            @(posedge clk); #1;
            cpu_req.valid = 1'b0;
            if (c == 4) begin
                rst     = 1'b1;
                mem_res = '{data: JUNK, ready: 1'b1};
            end
            #1;
            if (c >= 2) begin
                chk($sformatf("rstalloc.valid_c%0d", c), 128'(mem_req.valid), 128'(1));
                chk($sformatf("rstalloc.addr_c%0d", c),  128'(mem_req.addr),  128'(32'h0000_3FF0));
            end
        end
        chk("rstalloc.no_tag_we", 128'(tag_req.we), 128'(0));
        @(posedge clk); #1;
        rst     = 1'b0;
        mem_res = '0;
        #1;
        chk("rstalloc.mem_valid_after", 128'(mem_req.valid), 128'(0));
        chk("rstalloc.cpu_ready_after", 128'(cpu_res.ready), 128'(0));
        chk("rstalloc.tag_unchanged",   128'(tag_mem[10'h3FF]), 128'(20'hBFFFF));
        chk("rstalloc.line_unchanged",  data_mem[10'h3FF], L4);

        apply_vec(retry_vec, "retry");

        $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/dm_cache_ctrl.md
DM_CACHE_CTRL -- requirements
Module: dm_cache_ctrl

Interface
REQ-001 SHALL have no parameters; geometry comes from cache_def_pkg (CACHE_INDEX=1024, 32-bit address, tag=addr[31:14], index=addr[13:4], word=addr[3:2], 128-bit line).
REQ-002 clk  in  1  single clock; all state changes on posedge(clk).
REQ-003 rst  in  1  reset, synchronous, active-high.
REQ-004 cpu_req  in  cpu_req_type  {addr 32, data 32, rw 1 (1=write), valid 1}.
REQ-005 cpu_res  out  cpu_result_type  {data 32, ready 1}.
REQ-006 mem_req  out  mem_req_type  {addr 32, data 128, rw 1, valid 1}.
REQ-007 mem_res  in  mem_data_type  {data 128, ready 1}.
REQ-008 tag_req, data_req  out  cache_req_type  {index 10, we 1}, driving the tag and data memories.
REQ-009 tag_write  out  cache_tag_type  {valid 1, dirty 1, tag 18}; tag_read  in  cache_tag_type, combinational read of tag_req.index.
REQ-010 data_write  out  cache_data_type  128; data_read  in  cache_data_type, combinational read of data_req.index.

Function
REQ-011 SHALL implement FSM states IDLE, COMPARE_TAG, ALLOCATE, WRITE_BACK.
REQ-012 IDLE: on cpu_req.valid, SHALL latch addr/data/rw into req_q and go to COMPARE_TAG; cpu_req SHALL be ignored in all other states.
REQ-013 tag_req.index and data_req.index SHALL equal req_q.addr[13:4] in every state except IDLE, where they equal cpu_req.addr[13:4].
REQ-014 Hit = tag_read.valid && tag_read.tag == req_q.addr[31:14], evaluated in COMPARE_TAG.
REQ-015 Read hit: cpu_res.ready=1 for exactly one cycle; cpu_res.data = data_read word req_q.addr[3:2]; next IDLE.
REQ-016 Write hit: same ready pulse; data_req.we=1 with data_read where word addr[3:2] is replaced by req_q.data; tag_req.we=1 with {valid=1, dirty=1, same tag}; next IDLE.
REQ-017 Miss with victim valid && dirty: SHALL latch wb_addr={tag_read.tag, index, 4'b0} and wb_data=data_read; next WRITE_BACK.
REQ-018 Miss otherwise: next ALLOCATE; the tag and data memories SHALL NOT be written on a miss.
REQ-019 WRITE_BACK: mem_req={wb_addr, wb_data, rw=1, valid=1}, held stable until mem_res.ready; on ready, next ALLOCATE.
REQ-020 ALLOCATE: mem_req={req_q.addr[31:4],4'b0, rw=0, valid=1}, held stable until mem_res.ready.
REQ-021 On that ready: data_req.we=1 with mem_res.data; tag_req.we=1 with {1, 0, req_q tag}; next COMPARE_TAG, which then hits per REQ-015/016.
REQ-022 mem_req.valid SHALL be 0 in IDLE and COMPARE_TAG; cpu_res.ready SHALL be 0 outside COMPARE_TAG hit cycles.
REQ-023 Latency: hit ready at cycle N+1 after IDLE acceptance at N; miss ready exactly one cycle after the final mem_res.ready.
REQ-024 mem_res.ready outside WRITE_BACK/ALLOCATE SHALL be ignored; mem_res.ready in the first cycle of those states SHALL be honoured.
REQ-025 tag_req.we and data_req.we SHALL each be a single-cycle pulse, never asserted in IDLE or WRITE_BACK.

Reset
REQ-026 rst=1 at posedge SHALL force IDLE; clear req_q, wb_addr and wb_data; and zero cpu_res, mem_req and both we bits by the next cycle.
REQ-027 Reset during WRITE_BACK/ALLOCATE SHALL abandon the transaction, with no memory write; mem_req.valid SHALL be 0 the cycle after reset.
REQ-028 The controller SHALL NOT clear the tag memory; invalidation is by the memories' own initialisation.

Structure
REQ-029 cpu_req_type, cpu_result_type, mem_req_type, mem_data_type, cache_tag_type, cache_data_type, cache_req_type, TAGMSB=31, TAGLSB=14 and CACHE_INDEX SHALL live in cache_def_pkg.
REQ-030 The FSM state enum SHALL be local to dm_cache_ctrl; no sub-module; the word-merge function SHALL live in cache_def_pkg.

Verification
REQ-031 Cold read 0x0000_1004: ALLOCATE with mem_req.addr 0x0000_1000; mem_res.ready at cycle 5 with line 0x44..33..22..11 -> cpu_res.data=0x2222_2222 at cycle 6; tag index 0x100 = {1,0,0x00000}.
REQ-032 Write hit 0x0000_1008 data 0xDEAD_BEEF -> ready at N+1; line word2=0xDEAD_BEEF, other words unchanged; dirty=1.
REQ-033 Read 0x0004_1000 (same index, new tag) after REQ-032 -> WRITE_BACK first with addr 0x0000_1000 rw=1 and data holding 0xDEAD_BEEF; then ALLOCATE addr 0x0004_1000; then ready.
REQ-034 mem_res.ready delayed 20 cycles -> mem_req bit-stable throughout; no cpu_res.ready.
REQ-035 rst pulse in the 3rd ALLOCATE cycle -> next cycle IDLE, mem_req.valid=0; tag entry unchanged; a subsequent request misses again.
REQ-036 Back-to-back read hits with cpu_req.valid held -> one ready every 2 cycles; each cpu_res.data correct.
